// File: rtl/magic_buttons_if.sv
// rtl/magic_buttons_if.sv - button, keyboard and frame-timing signals shared with the NMI logic
interface magic_buttons_if;
  logic n_magic_in;
  logic kbd_magic;
  logic kbd_pause;
  logic n_int;
  logic n_int_next;
  logic magic_button;
  logic pause_button;
  logic reboot_req;
  logic btn_level;

  modport master (
    output n_magic_in, kbd_magic, kbd_pause, n_int, n_int_next,
    input  magic_button, pause_button, reboot_req, btn_level
  );

  modport slave (
    input  n_magic_in, kbd_magic, kbd_pause, n_int, n_int_next,
    output magic_button, pause_button, reboot_req, btn_level
  );
endinterface

// File: rtl/magic_buttons.sv
// rtl/magic_buttons.sv - debounced magic button, keyboard magic/pause latches, long-press reboot
module magic_buttons #(
  parameter logic [15:0] DEBOUNCE_CNT = 16'd28000,
  parameter logic [7:0]  LONG_FRAMES  = 8'd150
) (
  input logic            clk28,
  input logic            rst_n,
  magic_buttons_if.slave bus
);

  localparam logic [15:0] DB_LAST = DEBOUNCE_CNT - 16'd1;
  localparam logic [7:0]  LP_LAST = LONG_FRAMES - 8'd1;

  logic        sync_1;
  logic        sync_2;
  logic        pressed;
  logic        fs;
  logic [15:0] db_cnt;
  logic [7:0]  lp_cnt;
  logic        btn_level;
  logic        kbd_hold;
  logic        pause_hold;
  logic        magic_button;
  logic        pause_button;
  logic        reboot_req;

  // fs marks the cycle in which the NMI logic samples the button levels
  assign fs      = bus.n_int & ~bus.n_int_next;
  assign pressed = ~sync_2;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= bus.n_magic_in;
      sync_2 <= sync_1;
    end
  end

  // Any return to the accepted level throws away all accumulated credit
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt    <= 16'd0;
      btn_level <= 1'b0;
    end else if (pressed == btn_level) begin
      db_cnt <= 16'd0;
    end else if (db_cnt >= DB_LAST) begin
      db_cnt    <= 16'd0;
      btn_level <= pressed;
    end else begin
      db_cnt <= db_cnt + 16'd1;
    end
  end

  // Set wins over the fs clear so a pulse landing on fs is still seen next frame
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      kbd_hold   <= 1'b0;
      pause_hold <= 1'b0;
    end else begin
      if (bus.kbd_magic)  kbd_hold <= 1'b1;
      else if (fs)        kbd_hold <= 1'b0;
      if (bus.kbd_pause)  pause_hold <= 1'b1;
      else if (fs)        pause_hold <= 1'b0;
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      magic_button <= 1'b0;
      pause_button <= 1'b0;
    end else begin
      magic_button <= btn_level | kbd_hold;
      pause_button <= pause_hold;
    end
  end

  // Saturating frame count; reboot fires only on the step into saturation
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      lp_cnt     <= 8'd0;
      reboot_req <= 1'b0;
    end else if (!btn_level) begin
      lp_cnt     <= 8'd0;
      reboot_req <= 1'b0;
    end else begin
      reboot_req <= fs && (lp_cnt == LP_LAST);
      if (fs && (lp_cnt < LONG_FRAMES))
        lp_cnt <= lp_cnt + 8'd1;
    end
  end

  assign bus.magic_button = magic_button;
  assign bus.pause_button = pause_button;
  assign bus.reboot_req   = reboot_req;
  assign bus.btn_level    = btn_level;

endmodule

// File: tb/tb_magic_buttons.sv
// tb/tb_magic_buttons.sv - directed checks of debounce, keyboard latches and long-press reboot
module tb_magic_buttons;

  logic clk28 = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   reboot_count = 0;
  logic seen_bad;

  magic_buttons_if bus();

  magic_buttons #(.DEBOUNCE_CNT(16'd16), .LONG_FRAMES(8'd4)) dut (
    .clk28 (clk28),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk28 = ~clk28;

  always @(posedge clk28) if (bus.reboot_req === 1'b1) reboot_count++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk28);
  endtask

  task automatic fs_pulse();
    bus.n_int = 1'b1; bus.n_int_next = 1'b0;
    step();
    bus.n_int = 1'b0; bus.n_int_next = 1'b1;
  endtask

  initial begin
    bus.n_magic_in = 1'b1; bus.kbd_magic = 1'b0; bus.kbd_pause = 1'b0;
    bus.n_int = 1'b1; bus.n_int_next = 1'b1;
    step(3);
    chk("rst_btn_level", bus.btn_level, 0);
    chk("rst_magic", bus.magic_button, 0);
    chk("rst_pause", bus.pause_button, 0);
    chk("rst_reboot", bus.reboot_req, 0);
    rst_n = 1'b1;
    step(2);

    // short bounce must be rejected
    bus.n_magic_in = 1'b0;
    step(10);
    bus.n_magic_in = 1'b1;
    seen_bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.btn_level !== 1'b0 || bus.magic_button !== 1'b0) seen_bad = 1'b1;
    end
    chk("bounce_rejected", seen_bad, 0);

    // press acceptance latency: 2 sync + 16 debounce edges
    bus.n_magic_in = 1'b0;
    step(17); chk("press_btn_early", bus.btn_level, 0);
    step();   chk("press_btn", bus.btn_level, 1); chk("press_magic_lag", bus.magic_button, 0);
    step();   chk("press_magic", bus.magic_button, 1);

    // long press across 6 frames: one reboot right after the 4th
    for (int i = 1; i <= 6; i++) begin
      fs_pulse();
      chk($sformatf("long_reboot_fs%0d", i), bus.reboot_req, (i == 4) ? 1 : 0);
      step(2);
    end
    chk("long_reboot_count1", reboot_count, 1);
    chk("long_magic_held", bus.magic_button, 1);

    bus.n_magic_in = 1'b1;
    step(17); chk("release_btn_early", bus.btn_level, 1);
    step();   chk("release_btn", bus.btn_level, 0); chk("release_magic_lag", bus.magic_button, 1);
    step();   chk("release_magic", bus.magic_button, 0);

    bus.n_magic_in = 1'b0;
    step(19);
    for (int i = 1; i <= 4; i++) begin
      fs_pulse();
      chk($sformatf("rehold_reboot_fs%0d", i), bus.reboot_req, (i == 4) ? 1 : 0);
      step(2);
    end
    chk("rehold_reboot_count2", reboot_count, 2);
    bus.n_magic_in = 1'b1;
    step(20);
    chk("rehold_released", bus.btn_level, 0);

    // reset in the middle of a long press
    bus.n_magic_in = 1'b0;
    step(19);
    chk("mid_btn", bus.btn_level, 1);
    for (int i = 0; i < 3; i++) begin
      fs_pulse();
      step(2);
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_btn", bus.btn_level, 0);
    chk("mid_rst_magic", bus.magic_button, 0);
    chk("mid_rst_pause", bus.pause_button, 0);
    chk("mid_rst_reboot", bus.reboot_req, 0);
    step(3);
    chk("mid_rst_btn_hold", bus.btn_level, 0);
    chk("mid_rst_no_reboot", reboot_count, 2);
    rst_n = 1'b1;
    step(17); chk("mid_restart_early", bus.btn_level, 0);
    step();   chk("mid_restart_btn", bus.btn_level, 1);
    for (int i = 1; i <= 4; i++) begin
      fs_pulse();
      chk($sformatf("mid_restart_fs%0d", i), bus.reboot_req, (i == 4) ? 1 : 0);
      step(2);
    end
    chk("mid_reboot_count3", reboot_count, 3);
    bus.n_magic_in = 1'b1;
    step(20);

    // keyboard magic pulse, fs 100 cycles later
    bus.kbd_magic = 1'b1;
    step();
    bus.kbd_magic = 1'b0;
    chk("kbd_magic_p1", bus.magic_button, 0);
    step();   chk("kbd_magic_p2", bus.magic_button, 1);
    step(98); chk("kbd_magic_hold", bus.magic_button, 1);
    fs_pulse();
    chk("kbd_magic_fs", bus.magic_button, 1);
    step();   chk("kbd_magic_cleared", bus.magic_button, 0);

    // pulse coincident with fs survives to the next fs
    bus.kbd_magic = 1'b1; bus.n_int = 1'b1; bus.n_int_next = 1'b0;
    step();
    bus.kbd_magic = 1'b0; bus.n_int = 1'b0; bus.n_int_next = 1'b1;
    step();   chk("coinc_magic", bus.magic_button, 1);
    step(20); chk("coinc_magic_hold", bus.magic_button, 1);
    fs_pulse();
    chk("coinc_magic_fs", bus.magic_button, 1);
    step();   chk("coinc_magic_cleared", bus.magic_button, 0);

    // magic and pause together, then pause alone
    bus.kbd_magic = 1'b1; bus.kbd_pause = 1'b1;
    step();
    bus.kbd_magic = 1'b0; bus.kbd_pause = 1'b0;
    step();
    chk("both_magic", bus.magic_button, 1);
    chk("both_pause", bus.pause_button, 1);
    fs_pulse();
    chk("both_magic_fs", bus.magic_button, 1);
    chk("both_pause_fs", bus.pause_button, 1);
    step();
    chk("both_magic_clr", bus.magic_button, 0);
    chk("both_pause_clr", bus.pause_button, 0);
    bus.kbd_pause = 1'b1;
    step();
    bus.kbd_pause = 1'b0;
    step();
    chk("pause_only", bus.pause_button, 1);
    chk("pause_only_magic", bus.magic_button, 0);
    fs_pulse();
    step();
    chk("pause_only_clr", bus.pause_button, 0);

    // keyboard magic during a physical press: no glitch, no reboot credit
    bus.n_magic_in = 1'b0;
    step(19);
    chk("or_magic_btn", bus.magic_button, 1);
    bus.kbd_magic = 1'b1;
    step();
    bus.kbd_magic = 1'b0;
    seen_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.magic_button !== 1'b1) seen_bad = 1'b1;
    end
    fs_pulse();
    for (int i = 0; i < 5; i++) begin
      if (bus.magic_button !== 1'b1) seen_bad = 1'b1;
      step();
    end
    chk("or_no_glitch", seen_bad, 0);
    chk("or_reboot_count", reboot_count, 3);
    bus.n_magic_in = 1'b1;
    step(20);
    chk("or_released", bus.magic_button, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/magic_buttons.md
MAGIC_BUTTONS -- requirements
Module: magic_buttons

Interface
REQ-001 Parameter DEBOUNCE_CNT, 16'd28000, cycles a raw level must hold stable before acceptance (~1 ms at 28 MHz).
REQ-002 Parameter LONG_FRAMES, 8'd150, frame strobes of continuous physical press that produce a reboot request (~3 s).
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 clk28  input  1  system clock, 28 MHz; all logic clocked on its rising edge.
REQ-005 n_magic_in  input  1  raw physical magic button, active-low, asynchronous, bouncing.
REQ-006 kbd_magic  input  1  single-cycle pulse from keyboard decoder, magic key pressed.
REQ-007 kbd_pause  input  1  single-cycle pulse from keyboard decoder, pause key pressed.
REQ-008 n_int  input  1  current frame interrupt level, active-low.
REQ-009 n_int_next  input  1  n_int value for the next cycle.
REQ-010 magic_button  output  1  magic request level for NMI logic.
REQ-011 pause_button  output  1  pause request level for NMI logic.
REQ-012 reboot_req  output  1  single-cycle long-press reboot request.
REQ-013 btn_level  output  1  debounced physical button level, 1 = pressed.

Function
REQ-014 Frame strobe fs SHALL be n_int==1 && n_int_next==0, combinational, same cycle the NMI logic samples the buttons.
REQ-015 n_magic_in SHALL pass a 2-flop synchronizer; pressed = inverted synchronizer output.
REQ-016 Debounce: 16-bit counter cleared whenever pressed equals btn_level; otherwise increments; when it reaches DEBOUNCE_CNT-1 while still differing, btn_level takes pressed next cycle and counter clears.
REQ-017 Any return of pressed to btn_level before terminal count SHALL clear the counter; no partial credit.
REQ-018 Debounce counter SHALL not wrap; terminal count always resolves first.
REQ-019 Latch kbd_hold: set by kbd_magic; cleared in a cycle with fs; set has priority when kbd_magic and fs coincide.
REQ-020 Latch pause_hold: same rules as kbd_hold driven by kbd_pause.
REQ-021 magic_button SHALL be registered: btn_level || kbd_hold, one cycle after the source state.
REQ-022 pause_button SHALL be registered copy of pause_hold.
REQ-023 Consequence: every keyboard pulse yields magic_button/pause_button high on at least one fs cycle, then low from the cycle after that fs (unless re-pulsed).
REQ-024 Long-press counter (8-bit) SHALL increment on each fs while btn_level==1, clear whenever btn_level==0, saturate at LONG_FRAMES.
REQ-025 reboot_req SHALL pulse high exactly one cycle, the cycle after the counter first reaches LONG_FRAMES; no repeat until btn_level returns to 0 and a new long press completes.
REQ-026 Keyboard pulses SHALL not affect long-press counter; reboot only from physical button.
REQ-027 Simultaneous kbd_magic and physical press: magic_button is the OR; no double-count, no glitch low.

Reset
REQ-028 On rst_n low, immediately: synchronizer flops = 1 (released), btn_level=0, debounce and long-press counters=0, kbd_hold=0, pause_hold=0, magic_button=0, pause_button=0, reboot_req=0.
REQ-029 Reset mid-press SHALL discard progress; after release of rst_n with button held, full 2+DEBOUNCE_CNT cycle acceptance restarts.
REQ-030 Reset mid-long-press SHALL not emit reboot_req; frame count restarts at 0.

Verification
REQ-031 DEBOUNCE_CNT=16: n_magic_in low for 10 cycles then high -> btn_level and magic_button stay 0.
REQ-032 DEBOUNCE_CNT=16: n_magic_in held low -> btn_level=1 within 2+16+1 cycles, magic_button one cycle later; release -> both return 0 after same latency.
REQ-033 kbd_magic pulse, fs 100 cycles later -> magic_button high from pulse+2 through fs cycle, low from fs+2; pulse coincident with fs -> stays high until next fs.
REQ-034 LONG_FRAMES=4, button held across 6 fs -> exactly one reboot_req pulse after 4th fs; release and re-hold 4 fs -> second pulse.
REQ-035 Button held, 3 of 4 fs elapsed, rst_n pulsed -> no reboot_req; all outputs 0 during reset; acceptance restarts.
REQ-036 kbd_pause and kbd_magic same cycle -> both outputs high, each cleared independently after next fs.
